stage_fifo_wr_arb: RTL and testbench

// Arbitrates two dual-issue producers onto the single write port of a 2-deep dual-issue stage FIFO.

---
 rtl/stage_fifo_wr_arb_if.sv | 47 ++++
 rtl/stage_fifo_wr_arb.sv | 97 +++++++++
 tb/tb_stage_fifo_wr_arb.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/stage_fifo_wr_arb_if.sv
// Handshake bundle between the two dual-issue producers (P, S), the arbiter
// and the stage FIFO write port. Signal names keep the arbiter's point of
// view (_i = into the arbiter, _o = out of the arbiter).
//   slave  : arbiter side
//   master : environment side (producers + FIFO)
interface stage_fifo_wr_arb_if #(
  parameter int Width = 32
);
  logic [1:0]       p_valid_i;
  logic [Width-1:0] p_data0_i;
  logic [Width-1:0] p_data1_i;
  logic             p_lock_i;
  logic [1:0]       p_rdy_o;

  logic [1:0]       s_valid_i;
  logic [Width-1:0] s_data0_i;
  logic [Width-1:0] s_data1_i;
  logic             s_lock_i;
  logic [1:0]       s_rdy_o;

  logic [1:0]       fifo_wr_valid_o;
  logic [Width-1:0] fifo_wr_data0_o;
  logic [Width-1:0] fifo_wr_data1_o;
  logic [1:0]       fifo_wr_rdy_i;

  logic             owner_o;
  logic             locked_o;
  logic             starve_o;

  modport slave (
    input  p_valid_i, p_data0_i, p_data1_i, p_lock_i,
    input  s_valid_i, s_data0_i, s_data1_i, s_lock_i,
    input  fifo_wr_rdy_i,
    output p_rdy_o, s_rdy_o,
    output fifo_wr_valid_o, fifo_wr_data0_o, fifo_wr_data1_o,
    output owner_o, locked_o, starve_o
  );

  modport master (
    output p_valid_i, p_data0_i, p_data1_i, p_lock_i,
    output s_valid_i, s_data0_i, s_data1_i, s_lock_i,
    output fifo_wr_rdy_i,
    input  p_rdy_o, s_rdy_o,
    input  fifo_wr_valid_o, fifo_wr_data0_o, fifo_wr_data1_o,
    input  owner_o, locked_o, starve_o
  );
endinterface

// File: rtl/stage_fifo_wr_arb.sv
// Arbitrates a primary (P) and secondary (S) dual-issue producer onto the
// single write port of a 2-deep dual-issue stage FIFO. Grant and data are
// combinational (zero latency); lock state and the S starvation counter
// update on the clock edge. Supports multi-cycle lock bundles and a
// starvation guard that prioritises S after MaxWait waiting cycles.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous reset, active-high (also gates all handshakes)
//   flush_i : pipeline flush (gates all handshakes, returns to UNLOCKED)
//   bus     : producer / FIFO handshake bundle (slave modport)
module stage_fifo_wr_arb #(
  parameter int Width   = 32,
  parameter int MaxWait = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  stage_fifo_wr_arb_if.slave  bus
);

  localparam int              CntW   = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxWait);

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCK_P,
    LOCK_S
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             owner;      // 0 = P, 1 = S
  logic             starve;
  logic             gate;
  logic             xfer;
  logic             own_lock;
  logic [1:0]       own_valid;
  logic [Width-1:0] own_data0;
  logic [Width-1:0] own_data1;

  // Owner selection and data mux
  always_comb begin
    starve = (cnt_q == MaxCnt);
    gate   = rst_i | flush_i;
    owner  = 1'b0;
    case (state_q)
      LOCK_P:  owner = 1'b0;
      LOCK_S:  owner = 1'b1;
      default: owner = starve ? bus.s_valid_i[0] : ~bus.p_valid_i[0];
    endcase
    own_valid = owner ? bus.s_valid_i : bus.p_valid_i;
    own_data0 = owner ? bus.s_data0_i : bus.p_data0_i;
    own_data1 = owner ? bus.s_data1_i : bus.p_data1_i;
    own_lock  = owner ? bus.s_lock_i  : bus.p_lock_i;
    xfer      = own_valid[0] & bus.fifo_wr_rdy_i[0] & ~gate;
  end

  // Outputs: the non-owner always sees rdy 00, even while a locked owner
  // presents a bubble.
  always_comb begin
    bus.fifo_wr_valid_o = gate ? 2'b00 : own_valid;
    bus.fifo_wr_data0_o = own_data0;
    bus.fifo_wr_data1_o = own_data1;
    bus.p_rdy_o         = (gate || owner)  ? 2'b00 : bus.fifo_wr_rdy_i;
    bus.s_rdy_o         = (gate || !owner) ? 2'b00 : bus.fifo_wr_rdy_i;
    bus.owner_o         = owner;
    bus.locked_o        = (state_q != UNLOCKED);
    bus.starve_o        = starve;
  end

  // Next state / starvation counter; rst/flush override is in the register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      if (own_lock) state_d = owner ? LOCK_S : LOCK_P;
      else          state_d = UNLOCKED;
    end
    if (xfer && owner) begin
      cnt_d = '0;
    end else if (bus.s_valid_i[0] && !owner && !starve) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= UNLOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stage_fifo_wr_arb.sv
// Directed-vector bench for stage_fifo_wr_arb. The stimulus process drives
// one cycle of inputs at a time and queues the hand-computed response; a
// monitor on the falling edge pops and compares every presented cycle.
module tb_stage_fifo_wr_arb;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  stage_fifo_wr_arb_if #(.Width(32)) bus ();

  stage_fifo_wr_arb #(
    .Width   (32),
    .MaxWait (8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  vld;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  prdy;
    logic [1:0]  srdy;
    logic        own;
    logic        lck;
    logic        stv;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   done     = 1'b0;

  // One cycle of stimulus plus its expected response.
  task automatic step(input string name,
                      input logic [1:0] pv, input logic pl,
                      input logic [1:0] sv, input logic sl,
                      input logic [1:0] frdy, input logic fl, input logic rs,
                      input logic [1:0] e_vld, input logic [1:0] e_prdy,
                      input logic [1:0] e_srdy, input logic e_own,
                      input logic e_lck, input logic e_stv);
    exp_t e;
    cyc++;
    bus.p_valid_i     = pv;
    bus.p_lock_i      = pl;
    bus.p_data0_i     = 32'hA000_0000 | cyc;
    bus.p_data1_i     = 32'hA100_0000 | cyc;
    bus.s_valid_i     = sv;
    bus.s_lock_i      = sl;
    bus.s_data0_i     = 32'hB000_0000 | cyc;
    bus.s_data1_i     = 32'hB100_0000 | cyc;
    bus.fifo_wr_rdy_i = frdy;
    flush             = fl;
    rst               = rs;
    e.name = name;
    e.vld  = e_vld;
    e.d0   = (e_own ? 32'hB000_0000 : 32'hA000_0000) | cyc;
    e.d1   = (e_own ? 32'hB100_0000 : 32'hA100_0000) | cyc;
    e.prdy = e_prdy;
    e.srdy = e_srdy;
    e.own  = e_own;
    e.lck  = e_lck;
    e.stv  = e_stv;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (bus.fifo_wr_valid_o === e.vld) && (bus.p_rdy_o === e.prdy) &&
             (bus.s_rdy_o === e.srdy) && (bus.owner_o === e.own) &&
             (bus.locked_o === e.lck) && (bus.starve_o === e.stv);
        if (e.vld[0]) ok = ok && (bus.fifo_wr_data0_o === e.d0);
        if (e.vld[1]) ok = ok && (bus.fifo_wr_data1_o === e.d1);
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL %s: got vld=%b d0=%h d1=%h prdy=%b srdy=%b own=%b lck=%b stv=%b, want vld=%b d0=%h d1=%h prdy=%b srdy=%b own=%b lck=%b stv=%b",
                   e.name, bus.fifo_wr_valid_o, bus.fifo_wr_data0_o, bus.fifo_wr_data1_o,
                   bus.p_rdy_o, bus.s_rdy_o, bus.owner_o, bus.locked_o, bus.starve_o,
                   e.vld, e.d0, e.d1, e.prdy, e.srdy, e.own, e.lck, e.stv);
        end
        checks++;
        if (bus.fifo_wr_valid_o == 2'b10 || bus.p_rdy_o == 2'b10 || bus.s_rdy_o == 2'b10) begin
          failures++;
          $display("FAIL %s_legal: got vld=%b prdy=%b srdy=%b, want no 10 encoding",
                   e.name, bus.fifo_wr_valid_o, bus.p_rdy_o, bus.s_rdy_o);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: got no completion, want completion before time limit");
      $fatal(1, "timeout");
    end
  end

  initial begin
    bus.p_valid_i = 2'b00; bus.p_lock_i = 1'b0; bus.p_data0_i = '0; bus.p_data1_i = '0;
    bus.s_valid_i = 2'b00; bus.s_lock_i = 1'b0; bus.s_data0_i = '0; bus.s_data1_i = '0;
    bus.fifo_wr_rdy_i = 2'b00;
    flush = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    // name      pv    pl    sv    sl    frdy  fl    rs    vld   prdy  srdy  own   lck   stv
    step("reset",  2'b11,1'b0, 2'b00,1'b0, 2'b11,1'b0, 1'b1, 2'b00,2'b00,2'b00,1'b0, 1'b0, 1'b0);
    step("p_dual", 2'b11,1'b0, 2'b00,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0, 1'b0, 1'b0);
    step("partial",2'b11,1'b0, 2'b00,1'b0, 2'b01,1'b0, 1'b0, 2'b11,2'b01,2'b00,1'b0, 1'b0, 1'b0);

    // Starvation: counter at negedge of iteration k equals k.
    for (int k = 0; k < 8; k++)
      step("starve_wait", 2'b11,1'b0, 2'b01,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0,1'b0,1'b0);
    step("starve_hit", 2'b11,1'b0, 2'b01,1'b0, 2'b11,1'b0, 1'b0, 2'b01,2'b00,2'b11,1'b1, 1'b0, 1'b1);
    step("starve_clr", 2'b11,1'b0, 2'b00,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0, 1'b0, 1'b0);

    // S lock bundle with bubbles
    step("s_lock",  2'b00,1'b0, 2'b11,1'b1, 2'b11,1'b0, 1'b0, 2'b11,2'b00,2'b11,1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step("s_bubble", 2'b11,1'b0, 2'b00,1'b0, 2'b11,1'b0, 1'b0, 2'b00,2'b00,2'b11,1'b1,1'b1,1'b0);
    step("s_unlock",2'b11,1'b0, 2'b01,1'b0, 2'b11,1'b0, 1'b0, 2'b01,2'b00,2'b11,1'b1, 1'b1, 1'b0);
    step("p_after", 2'b11,1'b0, 2'b00,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0, 1'b0, 1'b0);

    // P lock: starvation saturates but does not break the lock
    step("p_lock",  2'b11,1'b1, 2'b01,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= 9; j++)
      step("p_locked", 2'b11,1'b1, 2'b01,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0,1'b1,
           (j >= 8) ? 1'b1 : 1'b0);
    step("flush",   2'b11,1'b1, 2'b01,1'b0, 2'b11,1'b1, 1'b0, 2'b00,2'b00,2'b00,1'b0, 1'b1, 1'b1);
    step("post_fl", 2'b11,1'b0, 2'b01,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0, 1'b0, 1'b0);

    // Reset held two cycles in the middle of an S lock
    step("s_lock2", 2'b00,1'b0, 2'b11,1'b1, 2'b11,1'b0, 1'b0, 2'b11,2'b00,2'b11,1'b1, 1'b0, 1'b0);
    step("s_bub2",  2'b11,1'b0, 2'b00,1'b0, 2'b11,1'b0, 1'b0, 2'b00,2'b00,2'b11,1'b1, 1'b1, 1'b0);
    step("rst_1",   2'b11,1'b0, 2'b11,1'b1, 2'b11,1'b0, 1'b1, 2'b00,2'b00,2'b00,1'b1, 1'b1, 1'b0);
    step("rst_2",   2'b11,1'b0, 2'b11,1'b1, 2'b11,1'b0, 1'b1, 2'b00,2'b00,2'b00,1'b0, 1'b0, 1'b0);
    step("post_rst",2'b11,1'b0, 2'b11,1'b0, 2'b11,1'b0, 1'b0, 2'b11,2'b11,2'b00,1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
